// File: rtl/poly_seq_pkg.sv
// poly_seq_pkg: shared definitions for the polynomial ALU sequencer.
//   state_t          - sequencer FSM states
//   MODE_* constants - bit positions inside the 10-bit ALU mode word
//   ALU_LAT_DEF      - default enable-to-valid latency of the ALU
//   LFSR_TAPS        - Fibonacci taps 16,14,13,11 as a bit mask
//   LFSR_ZERO_SUB    - replacement for an all-zero LFSR seed
package poly_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MODE_MM_B_SEL    = 8;
  localparam int MODE_MA_FEEDBACK = 9;

  localparam int ALU_LAT_DEF = 5;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/poly_seq_lfsr.sv
// poly_seq_lfsr: 16-bit Fibonacci LFSR that paces dummy-op insertion.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   load     - load from seed (a zero seed is replaced by LFSR_ZERO_SUB)
//   step     - advance one position
//   seed     - load value
//   value    - current LFSR state
module poly_seq_lfsr
  import poly_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      value <= {value[14:0], lfsr_feedback(value)};
    end
  end

endmodule

// File: rtl/poly_alu_seq.sv
// poly_alu_seq: command-driven sequencer for the polynomial ALU datapath.
// Accepts one vector command, streams coefficient read addresses (one per
// cycle), drives ALU enable/mode, and converts tagged ALU results into
// destination writes.
// Optional build macro: POLY_SEQ_DUMMY_EN inserts LFSR-paced dummy ops.
// Ports:
//   poly_clk, poly_rst          - clock, synchronous active-high reset
//   cmd_*                       - command fields, handshake cmd_valid/cmd_ready
//   lfsr_seed                   - dummy-insertion seed (used only with macro)
//   rd_en, rd_addr_a, rd_addr_b - coefficient RAM reads (1-cycle latency)
//   alu_enable, alu_mode, alu_decompose, alu_compress, alu_duv_mode - ALU controls
//   alu_valid                   - ALU result valid
//   wr_en, wr_addr              - destination writes of ALU results
//   busy, done, err             - status: non-idle, completion pulse, sticky misalignment
module poly_alu_seq
  import poly_seq_pkg::*;
#(
  parameter int AW      = 10,
  parameter int LW      = 9,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic          poly_clk,
  input  logic          poly_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [9:0]    cmd_mode,
  input  logic [1:0]    cmd_decompose,
  input  logic [1:0]    cmd_compress,
  input  logic [1:0]    cmd_duv_mode,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  input  logic [AW-1:0] cmd_dst,
  input  logic [LW-1:0] cmd_len,
  input  logic [15:0]   lfsr_seed,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic          alu_enable,
  output logic [9:0]    alu_mode,
  output logic [1:0]    alu_decompose,
  output logic [1:0]    alu_compress,
  output logic [1:0]    alu_duv_mode,
  input  logic          alu_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state;
  logic [AW-1:0] src_a_q, src_b_q, dst_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] icnt;   // real ops issued so far
  logic [LW-1:0] wcnt;   // destination writes completed so far
  logic          rd_tag; // tag of the op currently on rd_en: 1 real, 0 dummy
  logic [ALU_LAT:0] vld_pipe;
  logic [ALU_LAT:0] tag_pipe;
  logic          do_dummy;

`ifdef POLY_SEQ_DUMMY_EN
  logic [15:0] lfsr;
  logic [1:0]  dummy_run;
  logic        accept;

  assign accept = (state == IDLE) && cmd_valid;

  poly_seq_lfsr u_lfsr (
    .clk   (poly_clk),
    .rst   (poly_rst),
    .load  (accept),
    .step  (state == ISSUE),
    .seed  (lfsr_seed),
    .value (lfsr)
  );

  // Third consecutive candidate dummy is forced real.
  assign do_dummy = (lfsr[1:0] == 2'b00) && (dummy_run != 2'd2);
`else
  logic unused_seed;
  assign unused_seed = ^lfsr_seed;
  assign do_dummy    = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Results leave the ALU and go straight to the destination RAM.
  assign wr_en   = alu_valid && tag_pipe[ALU_LAT];
  assign wr_addr = dst_q + AW'(wcnt);

  // Read outputs are registered one step ahead: the op decided on an edge
  // appears on rd_en/rd_addr for the following cycle, so the first op is
  // issued on the accept edge and icnt counts ops already on the bus.
  always_ff @(posedge poly_clk) begin
    if (poly_rst) begin
      state         <= IDLE;
      src_a_q       <= '0;
      src_b_q       <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      icnt          <= '0;
      wcnt          <= '0;
      rd_tag        <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr_a     <= '0;
      rd_addr_b     <= '0;
      alu_enable    <= 1'b0;
      alu_mode      <= '0;
      alu_decompose <= '0;
      alu_compress  <= '0;
      alu_duv_mode  <= '0;
      vld_pipe      <= '0;
      tag_pipe      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
`ifdef POLY_SEQ_DUMMY_EN
      dummy_run     <= '0;
`endif
    end else begin
      // ---- ALU tracking: rd_en -> alu_enable -> ALU_LAT -> alu_valid ----
      alu_enable <= rd_en;
      vld_pipe   <= {vld_pipe[ALU_LAT-1:0], rd_en};
      tag_pipe   <= {tag_pipe[ALU_LAT-1:0], rd_en & rd_tag};
      if (alu_valid != vld_pipe[ALU_LAT]) err <= 1'b1;
      if (wr_en) wcnt <= wcnt + LW'(1);
      done <= 1'b0;

      // ---- command FSM ----
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_a_q       <= cmd_src_a;
            src_b_q       <= cmd_src_b;
            dst_q         <= cmd_dst;
            len_q         <= cmd_len;
            wcnt          <= '0;
            alu_mode      <= cmd_mode;
            alu_decompose <= cmd_decompose;
            alu_compress  <= cmd_compress;
            alu_duv_mode  <= cmd_duv_mode;
`ifdef POLY_SEQ_DUMMY_EN
            dummy_run     <= '0;
`endif
            if (cmd_len == '0) begin
              icnt  <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // First op is always real: a dummy needs a prior real address.
              icnt      <= LW'(1);
              rd_en     <= 1'b1;
              rd_tag    <= 1'b1;
              rd_addr_a <= cmd_src_a;
              rd_addr_b <= cmd_src_b;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (icnt == len_q) begin
            rd_en  <= 1'b0;
            rd_tag <= 1'b0;
            state  <= DRAIN;
          end else if (do_dummy) begin
            // Addresses held: the dummy repeats the previous real op.
            rd_en  <= 1'b1;
            rd_tag <= 1'b0;
`ifdef POLY_SEQ_DUMMY_EN
            dummy_run <= dummy_run + 2'd1;
`endif
          end else begin
            rd_en     <= 1'b1;
            rd_tag    <= 1'b1;
            rd_addr_a <= src_a_q + AW'(icnt);
            rd_addr_b <= src_b_q + AW'(icnt);
            icnt      <= icnt + LW'(1);
`ifdef POLY_SEQ_DUMMY_EN
            dummy_run <= '0;
`endif
          end
        end
        DRAIN: begin
          // Look ahead by the write in flight so done lands right after it.
          if ((wcnt + LW'(wr_en)) == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          alu_mode      <= '0;
          alu_decompose <= '0;
          alu_compress  <= '0;
          alu_duv_mode  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_alu_seq.sv
// tb_poly_alu_seq: directed self-checking bench for poly_alu_seq.
// An ALU stand-in turns alu_enable into alu_valid ALU_LAT cycles later,
// with knobs for early delivery and injected stray pulses.
module tb_poly_alu_seq;

  localparam int AW = 10;
  localparam int LW = 9;
  localparam int LAT = 5;

  logic          poly_clk = 1'b0;
  logic          poly_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [9:0]    cmd_mode = '0;
  logic [1:0]    cmd_decompose = '0, cmd_compress = '0, cmd_duv_mode = '0;
  logic [AW-1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [15:0]   lfsr_seed = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          alu_enable;
  logic [9:0]    alu_mode;
  logic [1:0]    alu_decompose, alu_compress, alu_duv_mode;
  logic          alu_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] en_d = '0;
  logic       early = 1'b0;
  logic       inject = 1'b0;

  always #5 poly_clk = ~poly_clk;

  always @(posedge poly_clk) en_d <= {en_d[6:0], alu_enable};
  assign alu_valid = (early ? en_d[LAT-2] : en_d[LAT-1]) | inject;

  poly_alu_seq #(.AW(AW), .LW(LW), .ALU_LAT(LAT)) dut (
    .poly_clk(poly_clk), .poly_rst(poly_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_decompose(cmd_decompose), .cmd_compress(cmd_compress),
    .cmd_duv_mode(cmd_duv_mode), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .lfsr_seed(lfsr_seed),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .alu_enable(alu_enable), .alu_mode(alu_mode),
    .alu_decompose(alu_decompose), .alu_compress(alu_compress),
    .alu_duv_mode(alu_duv_mode), .alu_valid(alu_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge poly_clk);
    poly_rst = 1'b1;
    @(negedge poly_clk);
    @(negedge poly_clk);
    poly_rst = 1'b0;
  endtask

  // Offers a command at a negedge; returns right after the accept edge (edge 0).
  task automatic start_cmd(input logic [LW-1:0] len, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input logic [9:0] mode);
    @(negedge poly_clk);
    cmd_len = len; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_mode = mode;
    cmd_decompose = 2'd1; cmd_compress = 2'd2; cmd_duv_mode = 2'd3;
    cmd_valid = 1'b1;
    @(posedge poly_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wrap_rd [4];
    logic [AW-1:0] wrap_wr [4];
    wrap_rd[0] = 10'h3FE; wrap_rd[1] = 10'h3FF; wrap_rd[2] = 10'h000; wrap_rd[3] = 10'h001;
    wrap_wr[0] = 10'h3FF; wrap_wr[1] = 10'h000; wrap_wr[2] = 10'h001; wrap_wr[3] = 10'h002;

    // ---- reset state ----
    @(negedge poly_clk);
    @(negedge poly_clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_alu_enable", 32'(alu_enable), 0);
    chk("rst_alu_mode", 32'(alu_mode), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    poly_rst = 1'b0;

    // ---- len=4 basic command ----
    start_cmd(9'd4, 10'h010, 10'h020, 10'h030, 10'h2A5);
    for (int k = 1; k <= 12; k++) begin
      @(negedge poly_clk);
      cmd_valid = 1'b0;
      chk("t1_rd_en", 32'(rd_en), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        chk("t1_rd_addr_a", 32'(rd_addr_a), 32'h010 + 32'(k - 1));
        chk("t1_rd_addr_b", 32'(rd_addr_b), 32'h020 + 32'(k - 1));
      end
      chk("t1_alu_enable", 32'(alu_enable), 32'(k >= 2 && k <= 5));
      chk("t1_wr_en", 32'(wr_en), 32'(k >= 7 && k <= 10));
      if (k >= 7 && k <= 10) chk("t1_wr_addr", 32'(wr_addr), 32'h030 + 32'(k - 7));
      chk("t1_done", 32'(done), 32'(k == 11));
      chk("t1_cmd_ready", 32'(cmd_ready), 32'(k == 12));
      chk("t1_alu_mode", 32'(alu_mode), (k <= 11) ? 32'h2A5 : 32'h0);
      if (k == 5) begin
        chk("t1_busy", 32'(busy), 1);
        chk("t1_compress", 32'(alu_compress), 2);
      end
    end
    chk("t1_err", 32'(err), 0);

    // ---- len=0 ----
    start_cmd(9'd0, 10'h100, 10'h200, 10'h300, 10'h001);
    for (int k = 1; k <= 10; k++) begin
      @(negedge poly_clk);
      cmd_valid = 1'b0;
      chk("t2_done", 32'(done), 32'(k == 1));
      chk("t2_rd_en", 32'(rd_en), 0);
      chk("t2_wr_en", 32'(wr_en), 0);
      if (k == 2) chk("t2_cmd_ready", 32'(cmd_ready), 1);
    end

    // ---- address wrap ----
    start_cmd(9'd4, 10'h3FE, 10'h100, 10'h3FF, 10'h155);
    for (int k = 1; k <= 12; k++) begin
      @(negedge poly_clk);
      cmd_valid = 1'b0;
      if (k >= 1 && k <= 4) chk("t3_rd_addr_a", 32'(rd_addr_a), 32'(wrap_rd[k-1]));
      if (k >= 7 && k <= 10) begin
        chk("t3_wr_en", 32'(wr_en), 1);
        chk("t3_wr_addr", 32'(wr_addr), 32'(wrap_wr[k-7]));
      end
      if (k == 11) chk("t3_done", 32'(done), 1);
    end
    chk("t3_err", 32'(err), 0);

    // ---- reset mid-command ----
    start_cmd(9'd8, 10'h040, 10'h080, 10'h0C0, 10'h3C3);
    for (int k = 1; k <= 16; k++) begin
      @(negedge poly_clk);
      cmd_valid = 1'b0;
      if (k == 4) begin
        chk("t4_rd_en", 32'(rd_en), 0);
        chk("t4_rd_addr_a", 32'(rd_addr_a), 0);
        chk("t4_alu_enable", 32'(alu_enable), 0);
        chk("t4_alu_mode", 32'(alu_mode), 0);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 0);
        chk("t4_cmd_ready", 32'(cmd_ready), 1);
      end
      if (k >= 4) chk("t4_wr_en", 32'(wr_en), 0);
      poly_rst = (k == 3);
      inject = (k == 5 || k == 9);
    end
    inject = 1'b0;
    do_reset();
    chk("t4_err_cleared", 32'(err), 0);

    // ---- early alu_valid -> sticky err ----
    early = 1'b1;
    start_cmd(9'd4, 10'h010, 10'h020, 10'h030, 10'h011);
    for (int k = 1; k <= 16; k++) begin
      @(negedge poly_clk);
      cmd_valid = 1'b0;
      if (k == 5) chk("t5_err_before", 32'(err), 0);
      if (k == 8) chk("t5_err_set", 32'(err), 1);
      if (k == 16) chk("t5_err_sticky", 32'(err), 1);
    end
    early = 1'b0;
    do_reset();
    chk("t5_err_after_reset", 32'(err), 0);
    chk("t5_cmd_ready_after_reset", 32'(cmd_ready), 1);

`ifdef POLY_SEQ_DUMMY_EN
    // ---- dummy insertion ----
    begin
      int wr_cnt = 0, en_cnt = 0, run = 0, max_run = 0, bad_addr = 0;
      logic prev_rd = 1'b0;
      logic [AW-1:0] prev_addr = '0;
      logic seen_done = 1'b0;
      lfsr_seed = 16'h1234;
      start_cmd(9'd256, 10'h000, 10'h100, 10'h200, 10'h0F0);
      for (int k = 1; k <= 3000 && !seen_done; k++) begin
        @(negedge poly_clk);
        cmd_valid = 1'b0;
        if (wr_en) begin
          if (wr_addr != 10'(10'h200 + wr_cnt)) bad_addr++;
          wr_cnt++;
        end
        if (alu_enable) en_cnt++;
        if (rd_en) begin
          if (prev_rd && rd_addr_a == prev_addr) run++;
          else run = 0;
          if (run > max_run) max_run = run;
        end
        prev_rd = rd_en;
        prev_addr = rd_addr_a;
        if (done) seen_done = 1'b1;
      end
      chk("t6_done_seen", 32'(seen_done), 1);
      chk("t6_wr_count", 32'(wr_cnt), 256);
      chk("t6_wr_contig", 32'(bad_addr), 0);
      chk("t6_en_gt_256", 32'(en_cnt > 256), 1);
      chk("t6_max_dummy_run_le2", 32'(max_run <= 2), 1);
      chk("t6_err", 32'(err), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
